// File: rtl/ahb_slave_frontend.sv
// AHB-Lite slave front end: address-phase capture, transfer validation, data-phase handshake.
// Define AHB_ALIGN_CHECK_EN to also reject misaligned half-word/word transfers.
module ahb_slave_frontend #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hsel,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [1:0]        hsize,
    input  logic [DATA_W-1:0] hwdata,
    input  logic              stall,
    input  logic [DATA_W-1:0] rdata,
    output logic              hready,
    output logic              hresp,
    output logic [DATA_W-1:0] hrdata,
    output logic [ADDR_W-1:0] haddr_reg,
    output logic [1:0]        hsize_reg,
    output logic              write_en,
    output logic              read_en,
    output logic [DATA_W-1:0] wdata
);
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t            state_q, state_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] haddr_q, haddr_d;
    logic [1:0]        hsize_q, hsize_d;
    logic              ready_int;
    logic              accept;
    logic              xfer_err;
    logic              beat;

    function automatic logic is_err(input logic [ADDR_W-1:0] a, input logic [1:0] sz,
                                    input logic wr);
        logic e;
        e = (int'(a) inside {9, 10, 11, 14, 15}) || (sz == 2'd3) ||
            (wr && (int'(a) inside {[4:8]}));
`ifdef AHB_ALIGN_CHECK_EN
        e = e || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
`endif
        return e;
    endfunction

    always_comb begin
        case (state_q)
            S_DATA:  ready_int = !stall;
            S_ERR1:  ready_int = 1'b0;
            default: ready_int = 1'b1;
        endcase
        accept   = hsel && htrans[1] && ready_int && !rst;
        xfer_err = is_err(haddr, hsize, hwrite);
        beat     = (state_q == S_DATA) && !stall && !rst;

        state_d = state_q;
        wr_d    = wr_q;
        haddr_d = haddr_q;
        hsize_d = hsize_q;
        // DATA without stall doubles as the next address phase (pipelined accept)
        case (state_q)
            S_ERR1: state_d = S_ERR2;
            S_DATA: if (!stall) state_d = accept ? (xfer_err ? S_ERR1 : S_DATA) : S_IDLE;
            default: state_d = accept ? (xfer_err ? S_ERR1 : S_DATA) : S_IDLE;
        endcase
        if (accept) begin
            wr_d    = hwrite;
            haddr_d = haddr;
            hsize_d = hsize;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            wr_q    <= 1'b0;
            haddr_q <= '0;
            hsize_q <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            haddr_q <= haddr_d;
            hsize_q <= hsize_d;
        end
    end

    // Reset masks everything so an aborted beat produces no strobe
    assign hready    = rst ? 1'b1 : ready_int;
    assign hresp     = !rst && (state_q == S_ERR1 || state_q == S_ERR2);
    assign write_en  = beat && wr_q;
    assign read_en   = beat && !wr_q;
    assign wdata     = (beat && wr_q) ? hwdata : '0;
    assign hrdata    = (beat && !wr_q) ? rdata : '0;
    assign haddr_reg = haddr_q;
    assign hsize_reg = hsize_q;
endmodule

// File: tb/tb_ahb_slave_frontend.sv
// Directed bench for ahb_slave_frontend: reset, write/read, stalls, error responses, pipelining.
module tb_ahb_slave_frontend;
    logic        clk = 1'b0;
    logic        rst;
    logic        hsel;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [3:0]  haddr;
    logic [1:0]  hsize;
    logic [31:0] hwdata;
    logic        stall;
    logic [31:0] rdata;
    logic        hready, hresp, write_en, read_en;
    logic [31:0] hrdata, wdata;
    logic [3:0]  haddr_reg;
    logic [1:0]  hsize_reg;

    int checks = 0;
    int errors = 0;

    ahb_slave_frontend #(.DATA_W(32), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .hsel(hsel), .htrans(htrans), .hwrite(hwrite),
        .haddr(haddr), .hsize(hsize), .hwdata(hwdata), .stall(stall), .rdata(rdata),
        .hready(hready), .hresp(hresp), .hrdata(hrdata), .haddr_reg(haddr_reg),
        .hsize_reg(hsize_reg), .write_en(write_en), .read_en(read_en), .wdata(wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge so new inputs form the next cycle
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic addr_ph(input logic [1:0] tr, input logic wr, input logic [3:0] a,
                           input logic [1:0] sz);
        hsel = 1'b1; htrans = tr; hwrite = wr; haddr = a; hsize = sz;
    endtask

    task automatic idle_ph();
        hsel = 1'b0; htrans = 2'd0; hwrite = 1'b0; haddr = 4'd0; hsize = 2'd0;
    endtask

    task automatic chk_hs(input string tag, input logic rdy, input logic rsp,
                          input logic we, input logic re);
        @(negedge clk);
        chk({tag, ".hready"}, 32'(hready), 32'(rdy));
        chk({tag, ".hresp"}, 32'(hresp), 32'(rsp));
        chk({tag, ".write_en"}, 32'(write_en), 32'(we));
        chk({tag, ".read_en"}, 32'(read_en), 32'(re));
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; rdata = 32'h0; hwdata = 32'h0;
        addr_ph(2'd2, 1'b1, 4'h0, 2'd2);
        // Reset held with an active request on the bus
        next_cycle();
        chk_hs("rst0", 1, 0, 0, 0);
        chk("rst0.haddr_reg", 32'(haddr_reg), 0);
        chk("rst0.hsize_reg", 32'(hsize_reg), 0);
        chk("rst0.hrdata", hrdata, 0);
        chk("rst0.wdata", wdata, 0);
        next_cycle();
        chk_hs("rst1", 1, 0, 0, 0);

        rst = 1'b0; idle_ph();
        next_cycle();
        // Word write to 0x0
        addr_ph(2'd2, 1'b1, 4'h0, 2'd2);
        chk_hs("wr.addr", 1, 0, 0, 0);
        next_cycle();
        idle_ph(); hwdata = 32'hDEADBEEF;
        chk_hs("wr.data", 1, 0, 1, 0);
        chk("wr.wdata", wdata, 32'hDEADBEEF);
        chk("wr.haddr_reg", 32'(haddr_reg), 0);
        chk("wr.hsize_reg", 32'(hsize_reg), 2);

        // Read of 0x8 with two stall cycles
        next_cycle();
        addr_ph(2'd2, 1'b0, 4'h8, 2'd2); hwdata = 32'h0;
        chk_hs("rd.addr", 1, 0, 0, 0);
        next_cycle();
        idle_ph(); stall = 1'b1; rdata = 32'h0000000C;
        chk_hs("rd.stall0", 0, 0, 0, 0);
        chk("rd.stall0.hrdata", hrdata, 0);
        next_cycle();
        chk_hs("rd.stall1", 0, 0, 0, 0);
        chk("rd.stall1.haddr_reg", 32'(haddr_reg), 8);
        next_cycle();
        stall = 1'b0;
        chk_hs("rd.beat", 1, 0, 0, 1);
        chk("rd.hrdata", hrdata, 32'hC);

        // Write to read-only 0x4; next request lands in ERR2
        next_cycle();
        rdata = 32'h0;
        addr_ph(2'd2, 1'b1, 4'h4, 2'd2);
        next_cycle();
        idle_ph();
        chk_hs("ro.err1", 0, 1, 0, 0);
        chk("ro.haddr_reg", 32'(haddr_reg), 4);
        next_cycle();
        addr_ph(2'd2, 1'b0, 4'hE, 2'd2);
        chk_hs("ro.err2", 1, 1, 0, 0);
        next_cycle();
        idle_ph();
        chk_hs("unm.err1", 0, 1, 0, 0);
        chk("unm.haddr_reg", 32'(haddr_reg), 14);
        next_cycle();
        addr_ph(2'd2, 1'b0, 4'h0, 2'd3);
        chk_hs("unm.err2", 1, 1, 0, 0);
        next_cycle();
        idle_ph();
        chk_hs("sz3.err1", 0, 1, 0, 0);
        chk("sz3.hsize_reg", 32'(hsize_reg), 3);
        next_cycle();
        chk_hs("sz3.err2", 1, 1, 0, 0);
        next_cycle();
        chk_hs("err.done", 1, 0, 0, 0);

        // Back-to-back NONSEQ write 0xC, SEQ byte read 0xD
        addr_ph(2'd2, 1'b1, 4'hC, 2'd2);
        next_cycle();
        addr_ph(2'd3, 1'b0, 4'hD, 2'd0); hwdata = 32'h12345678;
        chk_hs("b2b.wr", 1, 0, 1, 0);
        chk("b2b.wdata", wdata, 32'h12345678);
        next_cycle();
        idle_ph(); hwdata = 32'h0; rdata = 32'h000000AB;
        chk_hs("b2b.rd", 1, 0, 0, 1);
        chk("b2b.hrdata", hrdata, 32'hAB);
        chk("b2b.haddr_reg", 32'(haddr_reg), 13);

        // BUSY is not a transfer
        next_cycle();
        rdata = 32'h0;
        addr_ph(2'd1, 1'b1, 4'h0, 2'd2);
        next_cycle();
        idle_ph();
        chk_hs("busy", 1, 0, 0, 0);

        // Misaligned word write at 0x2
        next_cycle();
        addr_ph(2'd2, 1'b1, 4'h2, 2'd2);
        next_cycle();
        idle_ph(); hwdata = 32'h55;
`ifdef AHB_ALIGN_CHECK_EN
        chk_hs("align.err1", 0, 1, 0, 0);
        next_cycle();
        chk_hs("align.err2", 1, 1, 0, 0);
`else
        chk_hs("align.wr", 1, 0, 1, 0);
        chk("align.haddr_reg", 32'(haddr_reg), 2);
`endif

        // Reset in the data phase suppresses the strobe
        next_cycle();
        addr_ph(2'd2, 1'b1, 4'h1, 2'd0); hwdata = 32'h0;
        next_cycle();
        idle_ph(); rst = 1'b1; hwdata = 32'h77;
        chk_hs("rstmid", 1, 0, 0, 0);
        chk("rstmid.wdata", wdata, 0);
        next_cycle();
        rst = 1'b0;
        chk("rstmid.haddr_reg", 32'(haddr_reg), 0);

        next_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
